// File: rtl/execute_pipe_pkg.sv
// Shared types for the registered execute stage: ALU op encodings, funct codes,
// ALU control, FSM states and the decode helper.
package exe_pkg;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_RTYPE = 2'b10, OP_ILL = 2'b11} alu_op_e;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  typedef enum logic [3:0] {
    C_AND, C_OR, C_ADD, C_SUB, C_SLT, C_SLTU, C_NOR, C_SLL, C_SRL, C_SRA, C_MUL
  } alu_ctrl_e;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} exe_state_e;

  typedef struct packed {
    alu_ctrl_e ctrl;
    logic      is_signed;
    logic      illegal;
  } alu_dec_t;

  function automatic alu_dec_t decode(input logic [1:0] op, input logic [5:0] fn);
    alu_dec_t d;
    d = '{ctrl: C_ADD, is_signed: 1'b0, illegal: 1'b0};
    case (alu_op_e'(op))
      OP_ADD:   d.ctrl = C_ADD;
      OP_SUB:   d.ctrl = C_SUB;
      OP_RTYPE: begin
        case (fn)
          FN_ADD:   d.ctrl = C_ADD;
          FN_SUB:   d.ctrl = C_SUB;
          FN_AND:   d.ctrl = C_AND;
          FN_OR:    d.ctrl = C_OR;
          FN_NOR:   d.ctrl = C_NOR;
          FN_SLT:   d.ctrl = C_SLT;
          FN_SLTU:  d.ctrl = C_SLTU;
          FN_SLL:   d.ctrl = C_SLL;
          FN_SRL:   d.ctrl = C_SRL;
          FN_SRA:   d.ctrl = C_SRA;
          FN_MULT:  begin d.ctrl = C_MUL; d.is_signed = 1'b1; end
          FN_MULTU: d.ctrl = C_MUL;
          default:  d.illegal = 1'b1;
        endcase
      end
      default:  d.illegal = 1'b1;
    endcase
    return d;
  endfunction
endpackage

// File: rtl/execute_pipe_seq_multiplier.sv
// Iterative shift-add multiplier, one multiplier bit per cycle. Signed operands
// are multiplied as magnitudes and the product negated at the output.
module seq_multiplier #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              is_signed,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [2*XLEN-1:0] product
);
  localparam int CW = $clog2(XLEN);

  logic [2*XLEN-1:0] acc, mcand;
  logic [XLEN-1:0]   mplier;
  logic [CW-1:0]     cnt;
  logic              neg;

  logic            a_neg, b_neg;
  logic [XLEN-1:0] mag_a, mag_b;
  assign a_neg = is_signed & a[XLEN-1];
  assign b_neg = is_signed & b[XLEN-1];
  assign mag_a = a_neg ? -a : a;
  assign mag_b = b_neg ? -b : b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0; mcand <= '0; mplier <= '0; cnt <= '0; neg <= 1'b0; busy <= 1'b0;
    end else if (abort) begin
      busy <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= {{XLEN{1'b0}}, mag_a};
      mplier <= mag_b;
      cnt    <= CW'(XLEN - 1);
      neg    <= a_neg ^ b_neg;
      busy   <= 1'b1;
    end else if (busy) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 1'b1;
      if (cnt == '0) busy <= 1'b0;
    end
  end

  // High during the cycle that retires the last bit; product is final after that edge.
  assign done    = busy && (cnt == '0);
  assign product = neg ? -acc : acc;
endmodule

// File: rtl/execute_pipe.sv
// Registered execute stage with valid/ready on both sides; combinational ALU,
// iterative multiply that holds the stage until the product is handed off.
module execute_pipe
  import exe_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int BR_SHIFT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] read_data_1,
  input  logic [XLEN-1:0] read_data_2,
  input  logic [XLEN-1:0] extended_offset,
  input  logic [XLEN-1:0] old_address,
  input  logic [1:0]      alu_op,
  input  logic            alu_src,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] mul_hi,
  output logic            zero,
  output logic [XLEN-1:0] new_address,
  output logic            illegal
);
  localparam int SHW = $clog2(XLEN);

  exe_state_e        state;
  alu_dec_t          dec;
  logic [XLEN-1:0]   a, b, res, br;
  logic [SHW-1:0]    sh;
  logic              accept, is_mul, mul_busy, mul_done;
  logic [2*XLEN-1:0] product;

  assign a   = read_data_1;
  assign b   = alu_src ? extended_offset : read_data_2;
  assign sh  = b[SHW-1:0];
  assign dec = decode(alu_op, extended_offset[5:0]);
  assign br  = old_address + (extended_offset << BR_SHIFT);

  always_comb begin
    res = '0;
    case (dec.ctrl)
      C_AND:   res = a & b;
      C_OR:    res = a | b;
      C_ADD:   res = a + b;
      C_SUB:   res = a - b;
      C_NOR:   res = ~(a | b);
      C_SLT:   res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      C_SLTU:  res = {{(XLEN-1){1'b0}}, a < b};
      C_SLL:   res = a << sh;
      C_SRL:   res = a >> sh;
      C_SRA:   res = $signed(a) >>> sh;
      default: res = '0;
    endcase
    if (dec.illegal) res = '0;
  end

  assign in_ready = rst_n && !flush && (state == S_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = (dec.ctrl == C_MUL) && !dec.illegal;

  seq_multiplier #(.XLEN(XLEN)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (accept && is_mul),
    .abort     (flush),
    .is_signed (dec.is_signed),
    .a         (a),
    .b         (b),
    .busy      (mul_busy),
    .done      (mul_done),
    .product   (product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE; out_valid <= 1'b0; alu_result <= '0; mul_hi <= '0;
      zero <= 1'b0; new_address <= '0; illegal <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (flush) begin
        out_valid <= 1'b0;
        state     <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (accept) begin
            // Branch target is captured at issue; outputs are invalid while a multiply runs.
            new_address <= br;
            if (is_mul) state <= S_MUL;
            else begin
              alu_result <= res;
              mul_hi     <= '0;
              zero       <= (res == '0);
              illegal    <= dec.illegal;
              out_valid  <= 1'b1;
            end
          end
          S_MUL: if (mul_done) state <= S_DONE;
          S_DONE: if (!out_valid || out_ready) begin
            {mul_hi, alu_result} <= product;
            zero      <= (product[XLEN-1:0] == '0);
            illegal   <= 1'b0;
            out_valid <= 1'b1;
            state     <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  logic unused;
  assign unused = mul_busy;
endmodule

// File: tb/tb_execute_pipe.sv
// Directed bench for execute_pipe: reset, ALU ops, multiply latency/results,
// backpressure, flush and illegal decode, each with hand-computed expectations.
module tb_execute_pipe;
  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, alu_src, out_valid, out_ready, zero, illegal;
  logic [31:0] read_data_1, read_data_2, extended_offset, old_address;
  logic [31:0] alu_result, mul_hi, new_address;
  logic [1:0]  alu_op;
  int          vectors = 0, miscompares = 0;

  execute_pipe #(.XLEN(32), .BR_SHIFT(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .read_data_1(read_data_1), .read_data_2(read_data_2), .extended_offset(extended_offset),
    .old_address(old_address), .alu_op(alu_op), .alu_src(alu_src), .out_valid(out_valid),
    .out_ready(out_ready), .alu_result(alu_result), .mul_hi(mul_hi), .zero(zero),
    .new_address(new_address), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_op(input logic [1:0] op, input logic src, input logic [31:0] a, b, imm, old);
    alu_op = op; alu_src = src; read_data_1 = a; read_data_2 = b;
    extended_offset = imm; old_address = old;
  endtask

  // Presents one operation, waits (bounded) for in_ready, lets it transfer, then drops in_valid.
  task automatic issue(input logic [1:0] op, input logic src, input logic [31:0] a, b, imm, old);
    set_op(op, src, a, b, imm, old);
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (in_ready) break;
      step();
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL issue_ready: in_ready=%b required 1", in_ready);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
    set_op(2'b00, 1'b0, 32'd3, 32'd4, 32'h40, 32'h200);
    issue(2'b00, 1'b0, 32'd3, 32'd4, 32'h40, 32'h200);
    in_valid = 1'b1;
    rst_n = 1'b0; #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    vectors++;
    if ({alu_result, mul_hi, new_address, zero, illegal} !== '0) begin
      miscompares++; $display("FAIL rst_outputs: res=%h hi=%h na=%h z=%b ill=%b want all 0",
                              alu_result, mul_hi, new_address, zero, illegal);
    end
    step(); step();
    rst_n = 1'b1; in_valid = 1'b0;
    step();
    issue(2'b00, 1'b1, 32'd5, 32'd0, 32'd7, 32'h0);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL add_valid: got %b want 1", out_valid); end
    vectors++; if (alu_result !== 32'd12) begin miscompares++; $display("FAIL add_result: got %h want 0000000c", alu_result); end
    vectors++; if (zero !== 1'b0) begin miscompares++; $display("FAIL add_zero: got %b want 0", zero); end
  endtask

  task automatic test_alu();
    issue(2'b10, 1'b0, 32'd9, 32'd9, 32'h22, 32'h100);
    vectors++; if (alu_result !== 32'h0 || zero !== 1'b1) begin miscompares++; $display("FAIL sub_zero: res=%h z=%b want 0 1", alu_result, zero); end
    vectors++; if (new_address !== 32'h188) begin miscompares++; $display("FAIL sub_branch: got %h want 00000188", new_address); end
    issue(2'b00, 1'b0, 32'd1, 32'd2, 32'hFFFF_FFFF, 32'h100);
    vectors++; if (new_address !== 32'hFC) begin miscompares++; $display("FAIL branch_neg: got %h want 000000fc", new_address); end
    vectors++; if (alu_result !== 32'd3) begin miscompares++; $display("FAIL add_reg: got %h want 00000003", alu_result); end
    issue(2'b01, 1'b0, 32'd2, 32'd5, 32'h0, 32'h0);
    vectors++; if (alu_result !== 32'hFFFF_FFFD) begin miscompares++; $display("FAIL sub_wrap: got %h want fffffffd", alu_result); end
    issue(2'b10, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h2A, 32'h0);
    vectors++; if (alu_result !== 32'd1) begin miscompares++; $display("FAIL slt: got %h want 00000001", alu_result); end
    issue(2'b10, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h2B, 32'h0);
    vectors++; if (alu_result !== 32'd0 || zero !== 1'b1) begin miscompares++; $display("FAIL sltu: res=%h z=%b want 0 1", alu_result, zero); end
    issue(2'b10, 1'b0, 32'h8000_0000, 32'd4, 32'h03, 32'h0);
    vectors++; if (alu_result !== 32'hF800_0000) begin miscompares++; $display("FAIL sra: got %h want f8000000", alu_result); end
    issue(2'b10, 1'b0, 32'h8000_0000, 32'h24, 32'h02, 32'h0);
    vectors++; if (alu_result !== 32'h0800_0000) begin miscompares++; $display("FAIL srl_mask: got %h want 08000000", alu_result); end
    issue(2'b10, 1'b0, 32'h0000_0003, 32'd31, 32'h00, 32'h0);
    vectors++; if (alu_result !== 32'h8000_0000) begin miscompares++; $display("FAIL sll: got %h want 80000000", alu_result); end
    issue(2'b10, 1'b0, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'h27, 32'h0);
    vectors++; if (alu_result !== 32'h0000_0F0F) begin miscompares++; $display("FAIL nor: got %h want 00000f0f", alu_result); end
    issue(2'b10, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h24, 32'h0);
    vectors++; if (alu_result !== 32'h00F0_00F0) begin miscompares++; $display("FAIL and: got %h want 00f000f0", alu_result); end
    issue(2'b10, 1'b0, 32'hF000_0000, 32'h0000_000F, 32'h25, 32'h0);
    vectors++; if (alu_result !== 32'hF000_000F) begin miscompares++; $display("FAIL or: got %h want f000000f", alu_result); end
  endtask

  task automatic test_mult();
    int busy_cycles;
    issue(2'b10, 1'b0, 32'hFFFF_FFFD, 32'd7, 32'h18, 32'h0);
    busy_cycles = 0;
    for (int i = 0; i < 100 && !out_valid; i++) begin
      if (!in_ready) busy_cycles++;
      step();
    end
    vectors++; if (busy_cycles != 33) begin miscompares++; $display("FAIL mult_latency: in_ready low %0d cycles want 33", busy_cycles); end
    vectors++; if (mul_hi !== 32'hFFFF_FFFF || alu_result !== 32'hFFFF_FFEB) begin
      miscompares++; $display("FAIL mult_signed: hi=%h lo=%h want ffffffff ffffffeb", mul_hi, alu_result); end
    vectors++; if (zero !== 1'b0 || out_valid !== 1'b1) begin miscompares++; $display("FAIL mult_flags: z=%b v=%b want 0 1", zero, out_valid); end
    issue(2'b10, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'h19, 32'h0);
    for (int i = 0; i < 100 && !out_valid; i++) step();
    vectors++; if (mul_hi !== 32'h1 || alu_result !== 32'hFFFF_FFFE) begin
      miscompares++; $display("FAIL multu: hi=%h lo=%h want 00000001 fffffffe", mul_hi, alu_result); end
    issue(2'b10, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h18, 32'h0);
    for (int i = 0; i < 100 && !out_valid; i++) step();
    vectors++; if (mul_hi !== 32'h0 || alu_result !== 32'h8000_0000) begin
      miscompares++; $display("FAIL mult_minint: hi=%h lo=%h want 00000000 80000000", mul_hi, alu_result); end
    issue(2'b00, 1'b0, 32'd1, 32'd1, 32'h0, 32'h0);
    vectors++; if (mul_hi !== 32'h0 || alu_result !== 32'd2) begin
      miscompares++; $display("FAIL mulhi_clear: hi=%h lo=%h want 0 2", mul_hi, alu_result); end
  endtask

  task automatic test_back_to_back();
    step();
    out_ready = 1'b0;
    set_op(2'b00, 1'b0, 32'd1, 32'd1, 32'h0, 32'h0); in_valid = 1'b1;
    step();
    set_op(2'b00, 1'b0, 32'd2, 32'd2, 32'h0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      vectors++; if (out_valid !== 1'b1 || alu_result !== 32'd2) begin
        miscompares++; $display("FAIL bp_hold%0d: v=%b res=%h want 1 2", i, out_valid, alu_result); end
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_stall%0d: in_ready=%b want 0", i, in_ready); end
      step();
    end
    out_ready = 1'b1; #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_passthru: in_ready=%b want 1", in_ready); end
    step();
    vectors++; if (out_valid !== 1'b1 || alu_result !== 32'd4) begin miscompares++; $display("FAIL bp_second: v=%b res=%h want 1 4", out_valid, alu_result); end
    set_op(2'b00, 1'b0, 32'd3, 32'd3, 32'h0, 32'h0);
    step();
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1 || alu_result !== 32'd6) begin miscompares++; $display("FAIL bp_third: v=%b res=%h want 1 6", out_valid, alu_result); end
    step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain: v=%b want 0", out_valid); end
  endtask

  task automatic test_flush_illegal();
    int spurious;
    issue(2'b10, 1'b0, 32'd3, 32'd5, 32'h18, 32'h0);
    for (int i = 0; i < 4; i++) step();
    flush = 1'b1;
    set_op(2'b00, 1'b0, 32'd1, 32'd1, 32'h0, 32'h0); in_valid = 1'b1; #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_block: in_ready=%b want 0", in_ready); end
    step();
    flush = 1'b0; in_valid = 1'b0; #1;
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++; $display("FAIL flush_state: v=%b rdy=%b want 0 1", out_valid, in_ready); end
    spurious = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) spurious++;
      step();
    end
    vectors++; if (spurious != 0) begin miscompares++; $display("FAIL flush_abandon: out_valid seen %0d cycles want 0", spurious); end
    issue(2'b10, 1'b0, 32'd5, 32'd5, 32'h3F, 32'h10);
    vectors++; if (illegal !== 1'b1 || alu_result !== 32'h0 || zero !== 1'b1) begin
      miscompares++; $display("FAIL illegal_funct: ill=%b res=%h z=%b want 1 0 1", illegal, alu_result, zero); end
    vectors++; if (new_address !== 32'h10C) begin miscompares++; $display("FAIL illegal_branch: got %h want 0000010c", new_address); end
    issue(2'b11, 1'b0, 32'd5, 32'd5, 32'h20, 32'h0);
    vectors++; if (illegal !== 1'b1 || alu_result !== 32'h0) begin miscompares++; $display("FAIL illegal_op: ill=%b res=%h want 1 0", illegal, alu_result); end
    issue(2'b00, 1'b0, 32'd5, 32'd5, 32'h0, 32'h0);
    vectors++; if (illegal !== 1'b0 || alu_result !== 32'd10) begin miscompares++; $display("FAIL illegal_clear: ill=%b res=%h want 0 a", illegal, alu_result); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mult();
    test_back_to_back();
    test_flush_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
